// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and its request sequencer:
//   - one-hot ALU op encodings (SUM, AND, OR, EOR, SR)
//   - sequencer FSM state type
//   - bit positions of the N/Z/C/V flags inside the 4-bit status vector
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_SUM = 5'b10000;
  localparam logic [OP_W-1:0] OP_AND = 5'b01000;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00100;
  localparam logic [OP_W-1:0] OP_EOR = 5'b00010;
  localparam logic [OP_W-1:0] OP_SR  = 5'b00001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    AGU_LO = 2'd2,
    AGU_HI = 2'd3
  } seq_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Zero test used for the Z flag.
  function automatic logic is_zero8(input logic [7:0] value);
    return (value == 8'h00);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 8-bit ALU with one-hot op select.
// Ports:
//   op           in  5  one-hot op (SUM/AND/OR/EOR/SR); anything else -> 0
//   a, b         in  8  operands
//   carry_in     in  1  carry into SUM
//   decimal_mode in  1  SUM performs BCD addition when high
//   result       out 8  op result
//   carry_out    out 1  SUM carry, or bit shifted out by SR
//   overflow     out 1  signed overflow of SUM
//   half_carry   out 1  carry out of the low nibble of SUM
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [7:0]      a,
  input  logic [7:0]      b,
  input  logic            carry_in,
  input  logic            decimal_mode,
  output logic [7:0]      result,
  output logic            carry_out,
  output logic            overflow,
  output logic            half_carry
);

  logic [8:0] w_bin_sum;
  logic [4:0] w_lo_sum;
  logic [4:0] w_hi_sum;
  logic       w_lo_dc;
  logic       w_hi_dc;
  logic [3:0] w_lo_adj;
  logic [3:0] w_hi_adj;

  // Binary and BCD adder terms; both are always computed, the op mux picks.
  always_comb begin
    w_bin_sum = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
    w_lo_sum  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, carry_in};
    w_lo_dc   = (w_lo_sum > 5'd9);
    w_lo_adj  = w_lo_dc ? (w_lo_sum[3:0] + 4'd6) : w_lo_sum[3:0];
    w_hi_sum  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, w_lo_dc};
    w_hi_dc   = (w_hi_sum > 5'd9);
    w_hi_adj  = w_hi_dc ? (w_hi_sum[3:0] + 4'd6) : w_hi_sum[3:0];
  end

  // Op select. Overflow is the binary signed-overflow rule in both modes.
  always_comb begin
    result     = 8'h00;
    carry_out  = 1'b0;
    overflow   = 1'b0;
    half_carry = 1'b0;
    case (op)
      OP_SUM: begin
        half_carry = w_lo_sum[4];
        overflow   = (a[7] == b[7]) && (w_bin_sum[7] != a[7]);
        if (decimal_mode) begin
          result    = {w_hi_adj, w_lo_adj};
          carry_out = w_hi_dc;
        end else begin
          result    = w_bin_sum[7:0];
          carry_out = w_bin_sum[8];
        end
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_EOR: result = a ^ b;
      OP_SR: begin
        result    = {1'b0, a[7:1]};
        carry_out = a[0];
      end
      default: begin
        result    = 8'h00;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Shares one 8-bit ALU between the execute stage (data ops with flag update)
// and the address generation unit (16-bit base + 8-bit index, second ALU pass
// only when the low byte carries, which is also the page-cross indication).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exec_req_valid/ready          execute request handshake (accept in IDLE)
//   exec_op/exec_a/exec_b         one-hot op and operands
//   exec_rsp_valid/exec_result    one-cycle result pulse and held result
//   agu_req_valid/ready           address request handshake (accept in IDLE)
//   agu_base/agu_index            16-bit base, unsigned 8-bit index
//   agu_rsp_valid/agu_addr        one-cycle pulse and held address
//   agu_page_cross                low-byte add carried
//   status_nzcv                   registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            exec_req_valid,
  output logic            exec_req_ready,
  input  logic [OP_W-1:0] exec_op,
  input  logic [7:0]      exec_a,
  input  logic [7:0]      exec_b,
  output logic            exec_rsp_valid,
  output logic [7:0]      exec_result,
  input  logic            agu_req_valid,
  output logic            agu_req_ready,
  input  logic [15:0]     agu_base,
  input  logic [7:0]      agu_index,
  output logic            agu_rsp_valid,
  output logic [15:0]     agu_addr,
  output logic            agu_page_cross,
  output logic [3:0]      status_nzcv
);

  seq_state_t      r_state;
  seq_state_t      w_next_state;
  logic            r_prio_agu;      // 1: agu wins the next contested IDLE cycle
  logic            w_grant_exec;
  logic            w_grant_agu;

  // ALU is fed only from these registers.
  logic [OP_W-1:0] r_alu_op;
  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  logic [7:0]      r_base_hi;
  logic [7:0]      r_addr_lo;

  logic            r_exec_rsp_valid;
  logic [7:0]      r_exec_result;
  logic            r_agu_rsp_valid;
  logic [15:0]     r_agu_addr;
  logic            r_agu_page_cross;
  logic [3:0]      r_status;

  logic [7:0]      w_alu_result;
  logic            w_alu_carry;
  logic            w_alu_overflow;
  logic            w_half_carry_unused;
  logic [3:0]      w_exec_flags;

  alu u_alu (
    .op           (r_alu_op),
    .a            (r_alu_a),
    .b            (r_alu_b),
    .carry_in     (1'b0),
    .decimal_mode (1'b0),
    .result       (w_alu_result),
    .carry_out    (w_alu_carry),
    .overflow     (w_alu_overflow),
    .half_carry   (w_half_carry_unused)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_exec) begin
          w_next_state = EXEC;
        end else if (w_grant_agu) begin
          w_next_state = AGU_LO;
        end else begin
          w_next_state = IDLE;
        end
      end
      EXEC:   w_next_state = IDLE;
      AGU_LO: w_next_state = w_alu_carry ? AGU_HI : IDLE;
      AGU_HI: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: round-robin grant, only in IDLE and never under reset.
  always_comb begin
    w_grant_exec = 1'b0;
    w_grant_agu  = 1'b0;
    if (!rst && (r_state == IDLE)) begin
      if (exec_req_valid && (!agu_req_valid || !r_prio_agu)) begin
        w_grant_exec = 1'b1;
      end else if (agu_req_valid) begin
        w_grant_agu = 1'b1;
      end else begin
        w_grant_exec = 1'b0;
        w_grant_agu  = 1'b0;
      end
    end else begin
      w_grant_exec = 1'b0;
      w_grant_agu  = 1'b0;
    end
  end

  assign exec_req_ready = w_grant_exec;
  assign agu_req_ready  = w_grant_agu;

  // Flag update for the exec result; an invalid op holds every flag.
  always_comb begin
    w_exec_flags = r_status;
    case (r_alu_op)
      OP_SUM: begin
        w_exec_flags[FLAG_N] = w_alu_result[7];
        w_exec_flags[FLAG_Z] = is_zero8(w_alu_result);
        w_exec_flags[FLAG_C] = w_alu_carry;
        w_exec_flags[FLAG_V] = w_alu_overflow;
      end
      OP_AND, OP_OR, OP_EOR: begin
        w_exec_flags[FLAG_N] = w_alu_result[7];
        w_exec_flags[FLAG_Z] = is_zero8(w_alu_result);
      end
      OP_SR: begin
        w_exec_flags[FLAG_N] = 1'b0;
        w_exec_flags[FLAG_Z] = is_zero8(w_alu_result);
        w_exec_flags[FLAG_C] = w_alu_carry;
      end
      default: w_exec_flags = r_status;
    endcase
  end

  // Round-robin pointer: the requester just granted loses the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_agu <= 1'b0;
    end else if (w_grant_exec) begin
      r_prio_agu <= 1'b1;
    end else if (w_grant_agu) begin
      r_prio_agu <= 1'b0;
    end else begin
      r_prio_agu <= r_prio_agu;
    end
  end

  // Operand latch, ALU sequencing and response/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_op         <= 5'b00000;
      r_alu_a          <= 8'h00;
      r_alu_b          <= 8'h00;
      r_base_hi        <= 8'h00;
      r_addr_lo        <= 8'h00;
      r_exec_rsp_valid <= 1'b0;
      r_exec_result    <= 8'h00;
      r_agu_rsp_valid  <= 1'b0;
      r_agu_addr       <= 16'h0000;
      r_agu_page_cross <= 1'b0;
      r_status         <= 4'b0000;
    end else begin
      r_exec_rsp_valid <= 1'b0;
      r_agu_rsp_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_exec) begin
            r_alu_op <= exec_op;
            r_alu_a  <= exec_a;
            r_alu_b  <= exec_b;
          end else if (w_grant_agu) begin
            r_alu_op  <= OP_SUM;
            r_alu_a   <= agu_base[7:0];
            r_alu_b   <= agu_index;
            r_base_hi <= agu_base[15:8];
          end
        end
        EXEC: begin
          r_exec_result    <= w_alu_result;
          r_status         <= w_exec_flags;
          r_exec_rsp_valid <= 1'b1;
        end
        AGU_LO: begin
          r_addr_lo <= w_alu_result;
          if (w_alu_carry) begin
            // Second pass increments the high byte; op stays SUM.
            r_alu_a <= r_base_hi;
            r_alu_b <= 8'h01;
          end else begin
            r_agu_addr       <= {r_base_hi, w_alu_result};
            r_agu_page_cross <= 1'b0;
            r_agu_rsp_valid  <= 1'b1;
          end
        end
        AGU_HI: begin
          // Carry out of the high byte is dropped: 0xFF wraps to 0x00.
          r_agu_addr       <= {w_alu_result, r_addr_lo};
          r_agu_page_cross <= 1'b1;
          r_agu_rsp_valid  <= 1'b1;
        end
        default: begin
          r_exec_rsp_valid <= 1'b0;
          r_agu_rsp_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign exec_rsp_valid = r_exec_rsp_valid;
  assign exec_result    = r_exec_result;
  assign agu_rsp_valid  = r_agu_rsp_valid;
  assign agu_addr       = r_agu_addr;
  assign agu_page_cross = r_agu_page_cross;
  assign status_nzcv    = r_status;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequences the shared 8-bit `alu` for two requesters: the execute stage (8-bit data ops with N/Z/C/V flag update) and the address generation unit (16-bit base + 8-bit index, two ALU passes when the low byte carries). It arbitrates between them, latches operands, drives the ALU, registers results and the status flags, and reports page crossings so the core can insert the 6502 extra cycle.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `exec_req_valid`  in  1  execute request.
- `exec_req_ready`  out  1  execute request accepted this cycle when both valid and ready are high.
- `exec_op`  in  5  one-hot op: SUM=10000, AND=01000, OR=00100, EOR=00010, SR=00001.
- `exec_a`, `exec_b`  in  8 each  operands.
- `exec_rsp_valid`  out  1  one-cycle result pulse.
- `exec_result`  out  8  result, valid with `exec_rsp_valid`.
- `agu_req_valid`  in  1  address request.
- `agu_req_ready`  out  1  address request accepted this cycle when both valid and ready are high.
- `agu_base`  in  16  base address.
- `agu_index`  in  8  unsigned index.
- `agu_rsp_valid`  out  1  one-cycle result pulse.
- `agu_addr`  out  16  `agu_base + agu_index` mod 2^16.
- `agu_page_cross`  out  1  high when the low-byte add carried.
- `status_nzcv`  out  4  flags {N,Z,C,V}, registered.

## Operation
- States: IDLE, EXEC, AGU_LO, AGU_HI.
- **Request acceptance**
  - Requests are accepted only in IDLE.
  - `*_req_ready` is 0 in every other state and while `rst` is high.
- **Arbitration (round-robin)**
  - When both requests are valid in IDLE, the requester not granted last wins.
  - After reset, priority goes to exec.
  - A lone valid requester is always granted.
  - At most one ready is high per cycle.
- **Operand latch**
  - On accept, operands and op are registered.
  - FSM moves to EXEC or AGU_LO.
- **EXEC**
  - ALU is driven with the latched a, b and op; the result is registered.
  - FSM returns to IDLE.
  - `exec_rsp_valid` pulses the following cycle.
- **EXEC flag updates**
  - SUM: N=r[7], Z=(r==0), C=ALU carry, V=ALU overflow.
  - AND/OR/EOR: N and Z update; C and V hold.
  - SR: N=0, Z=(r==0), C=a[0]; V holds.
  - Non-one-hot op: result 0, all flags hold, response still issued.
- **AGU_LO**
  - ALU SUM computes `base[7:0] + index`.
  - Result is latched as `addr[7:0]`; carry is latched as `page_cross`.
  - carry=0: `addr[15:8]=base[15:8]`, FSM goes to IDLE, response issued.
  - carry=1: FSM goes to AGU_HI.
- **AGU_HI**
  - ALU SUM computes `base[15:8] + 8'h01`.
  - ALU carry-out is discarded, so 0xFF wraps to 0x00.
  - Result latched as `addr[15:8]`; FSM goes to IDLE; response issued.
- AGU requests never modify `status_nzcv`.
- Responses have no backpressure. `exec_result`, `agu_addr` and `agu_page_cross` hold their values until overwritten by the next response.
- **Reset (including mid-operation)**
  - FSM returns to IDLE and the in-flight request is dropped with no response.
  - Round-robin pointer returns to favour exec.
  - All outputs go to 0: `exec_rsp_valid`, `exec_result`, `agu_rsp_valid`, `agu_addr`, `agu_page_cross`, `status_nzcv`, and both readies.

## Timing
- Accept at cycle T.
- EXEC: ALU evaluated in T+1. `exec_rsp_valid`, `exec_result` and updated `status_nzcv` are visible in T+2. Latency 2.
- AGU, no page cross: response at T+2.
- AGU, page cross: response at T+3, i.e. one extra cycle.
- FSM is in IDLE during the response cycle, so a new request is accepted there. Peak throughput is one exec op per 2 cycles.
- `status_nzcv` changes only in the exec response cycle.

## Structure
- Package `alu_pkg` holds:
  - one-hot op localparams (SUM, AND, OR, EOR, SR);
  - `seq_state_t` enum {IDLE, EXEC, AGU_LO, AGU_HI};
  - flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module: a single instance of the existing `alu`, driven only from latched registers.
  - `carry_in` is tied 0.
  - `decimal_mode` is tied 0.
  - `half_carry` is left unused.
- Everything else (FSM, arbiter pointer, operand and result registers) lives in `alu_sequencer`.

## Test plan
- Exec SUM a=0x50 b=0x50 accepted at T -> at T+2 `exec_result`=0xA0 and `status_nzcv`=4'b1001; no pulse at T+1.
- Exec SR a=0x81 -> result 0x40, N=0, Z=0, C=1, V unchanged. Then exec AND 0x0F & 0xF0 -> result 0x00, Z=1, C still 1.
- AGU base=0x1200 index=0x05 -> `agu_addr`=0x1205, `page_cross`=0 at T+2. Base=0x12F0 index=0x20 -> 0x1310, `page_cross`=1 at T+3. Base=0xFFF0 index=0x20 -> 0x0010, `page_cross`=1.
- Both valid continuously from reset release -> grants alternate exec, agu, exec, …. `status_nzcv` is unaffected by AGU responses.
- Assert `rst` during AGU_HI -> no `agu_rsp_valid`; all outputs 0 the next cycle; the first request after reset is accepted in the cycle `rst` is low.
- Exec op=5'b00011 -> result 0x00, flags unchanged, response at T+2.
